cache_mem_arbiter: RTL and testbench
====================================

# cache_mem_arbiter

Shares one burst memory port between the instruction cache (read-only) and the data cache (read + write-back) in the CPU's cache-to-AXI path. Cache line refills and uncached reads go through a single-outstanding read sequencer with round-robin arbitration. A one-entry write buffer serializes 128-bit victim lines into 32-bit beats. A read-after-write hazard check keeps dcache refills from overtaking a pending write-back to the same line.

## Interface
- Parameters: none. Widths are fixed: 32-bit address and data, 128-bit line, 4 beats per line.
- clk  in  1  clock; all logic on posedge.
- reset  in  1  asynchronous, active-high; clears all state.
- i_rd_req / d_rd_req  in  1 each  client read request; held until its rdy.
- i_rd_type / d_rd_type  in  3 each  3'b100 = line (4 beats); 3'b000/001/010 = single beat.
- i_rd_addr / d_rd_addr  in  32 each  read start address.
- i_rd_rdy / d_rd_rdy  out  1 each  read request accepted this cycle.
- i_ret_valid / d_ret_valid  out  1 each  return beat valid for that client.
- i_ret_last / d_ret_last  out  2 each  {1'b0, last beat}.
- cli_ret_data  out  32  return data, shared by both clients.
- d_wr_req  in  1  write request; asserted only while d_wr_rdy is high.
- d_wr_type  in  3  3'b100 = line write; otherwise single beat.
- d_wr_addr  in  32  write start address.
- d_wr_wstrb  in  4  byte strobe for single-beat writes; ignored for line writes.
- d_wr_data  in  128  line data, beat k = [32k+31:32k].
- d_wr_rdy  out  1  write buffer empty.
- mem_rd_req  out  1  downstream read address valid.
- mem_rd_addr  out  32  downstream read address.
- mem_rd_len  out  2  beats minus 1 (3 or 0).
- mem_rd_rdy  in  1  downstream accepts the read address.
- mem_ret_valid  in  1  downstream return beat; no backpressure.
- mem_ret_last  in  1  downstream last return beat.
- mem_ret_data  in  32  downstream return data.
- mem_wr_req  out  1  write beat valid.
- mem_wr_addr  out  32  write start address, constant for the whole burst.
- mem_wr_len  out  2  beats minus 1.
- mem_wr_strb  out  4  byte strobe.
- mem_wr_data  out  32  write beat data.
- mem_wr_last  out  1  final write beat.
- mem_wr_rdy  in  1  downstream accepts the current write beat.
- mem_wr_done  in  1  write response; one-cycle pulse.

## Operation
- Read FSM states: R_IDLE, R_REQ, R_DATA.
- R_IDLE arbitration:
  - Eligible clients are those with rd_req high. dcache is excluded on a hazard: d_rd_addr[31:4] equals the buffered write line (buffer valid, or being accepted this cycle).
  - One eligible client: it wins.
  - Both eligible: the client not granted last time wins.
  - The winner gets rdy=1 combinationally in the same cycle. Its addr and len are latched, the grant is latched, last_grant is updated, and the FSM moves to R_REQ.
- R_REQ: mem_rd_req=1 with the latched addr/len. On mem_rd_rdy, go to R_DATA.
- R_DATA: each mem_ret_valid is forwarded to the granted client (that client's ret_valid=1, ret_last={0,mem_ret_last}). On mem_ret_valid & mem_ret_last, return to R_IDLE.
- mem_ret_valid outside R_DATA is ignored.
- Write FSM states: W_IDLE, W_DATA, W_RESP.
- W_IDLE: d_wr_rdy=1. On d_wr_req, latch addr, type, strobe and line; beat counter=0; go to W_DATA.
- W_DATA:
  - mem_wr_req=1; mem_wr_data = line beat[cnt].
  - Strobe is 4'hf for line writes, latched wstrb for single-beat writes.
  - mem_wr_last = (cnt == len).
  - Each mem_wr_rdy advances cnt. A handshake on the last beat moves to W_RESP.
- W_RESP: wait for mem_wr_done, then go to W_IDLE. The buffer stays valid, and the hazard stays live, until this transition.
- The read and write FSMs run concurrently and independently.

## Timing
- Reset values: all req/valid/rdy/last outputs 0, except d_wr_rdy=1. mem_rd_len=0, mem_wr_len=0, all addr/data outputs 0. last_grant=dcache, so icache wins the first tie. Both FSMs start in idle.
- Reset asserted mid-burst: both FSMs go idle immediately and the write buffer is discarded. Downstream is reset concurrently.
- Read latency: rdy handshake in cycle T, mem_rd_req first asserted in T+1. Return beats reach the client in the same cycle they arrive (combinational path).
- A new read can be accepted in the cycle after the last return beat (R_IDLE).
- Write: handshake in T, first mem_wr_req in T+1. A line write with mem_wr_rdy tied high takes beats T+1..T+4, then waits for mem_wr_done. d_wr_rdy returns to 1 the cycle after mem_wr_done.
- Hazard release: a blocked dcache read may be granted in the first cycle d_wr_rdy is back at 1.

## Test plan
- icache line read @0x1000, mem_rd_rdy after 2 cycles, returns 0xA0..0xA3 -> i_rd_rdy pulses in the request cycle; mem_rd_len=3; i_ret_valid on 4 beats; i_ret_last=2'b01 only on 0xA3; d_ret_valid stays 0.
- Both clients request reads continuously for 4 transactions after reset -> grant order I, D, I, D.
- d_wr line @0x2000 with data words W0..W3, mem_wr_rdy toggling 1/0 -> beats W0..W3 in order, strobe 4'hf, mem_wr_last on W3, addr held 0x2000; d_wr_rdy=0 until the cycle after mem_wr_done.
- d_wr line @0x2000 pending, then d_rd_req @0x2008 plus i_rd_req @0x3000 -> icache granted; d_rd_rdy held 0 until after mem_wr_done, then dcache granted.
- Single-beat write with d_wr_type=3'b010, wstrb=4'b0011, data 0x1234 -> one beat, mem_wr_len=0, strb 4'b0011, mem_wr_last=1.
- reset asserted during R_DATA beat 2 -> all outputs at reset values at once; a fresh icache read completes normally afterwards.

Source files
------------

// File: rtl/cache_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : cache_mem_arbiter
// Purpose  : Shares one burst memory port between the icache (reads) and the
//            dcache (reads + write-backs). Reads go through a single
//            outstanding sequencer with round-robin arbitration. Writes go
//            through a one-entry buffer that splits a 128-bit line into four
//            32-bit beats. A dcache read that targets the line held in the
//            write buffer is held off until that write-back has completed.
// Ports    : clk, reset            clock / async active-high reset
//            i_rd_* / d_rd_*       client read requests and handshakes
//            i_ret_* / d_ret_*     per-client return beat valid / last
//            cli_ret_data          return data shared by both clients
//            d_wr_*                dcache write request and buffer ready
//            mem_rd_* / mem_ret_*  downstream read address / return channel
//            mem_wr_*              downstream write beat / response channel
// Revision : 1.0 - initial release
// ============================================================================
module cache_mem_arbiter (
  input  logic          clk,
  input  logic          reset,
  // client read side
  input  logic          i_rd_req,
  input  logic [2:0]    i_rd_type,
  input  logic [31:0]   i_rd_addr,
  output logic          i_rd_rdy,
  input  logic          d_rd_req,
  input  logic [2:0]    d_rd_type,
  input  logic [31:0]   d_rd_addr,
  output logic          d_rd_rdy,
  output logic          i_ret_valid,
  output logic [1:0]    i_ret_last,
  output logic          d_ret_valid,
  output logic [1:0]    d_ret_last,
  output logic [31:0]   cli_ret_data,
  // client write side
  input  logic          d_wr_req,
  input  logic [2:0]    d_wr_type,
  input  logic [31:0]   d_wr_addr,
  input  logic [3:0]    d_wr_wstrb,
  input  logic [127:0]  d_wr_data,
  output logic          d_wr_rdy,
  // downstream read
  output logic          mem_rd_req,
  output logic [31:0]   mem_rd_addr,
  output logic [1:0]    mem_rd_len,
  input  logic          mem_rd_rdy,
  input  logic          mem_ret_valid,
  input  logic          mem_ret_last,
  input  logic [31:0]   mem_ret_data,
  // downstream write
  output logic          mem_wr_req,
  output logic [31:0]   mem_wr_addr,
  output logic [1:0]    mem_wr_len,
  output logic [3:0]    mem_wr_strb,
  output logic [31:0]   mem_wr_data,
  output logic          mem_wr_last,
  input  logic          mem_wr_rdy,
  input  logic          mem_wr_done
);

  localparam logic [2:0] TYPE_LINE = 3'b100;
  localparam logic       GNT_I     = 1'b0;
  localparam logic       GNT_D     = 1'b1;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_REQ  = 2'd1,
    R_DATA = 2'd2
  } rd_state_t;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } wr_state_t;

  // --------------------------------------------------------------------------
  // Read sequencer state
  // --------------------------------------------------------------------------
  rd_state_t    rd_state_q, rd_state_d;
  logic [31:0]  rd_addr_q, rd_addr_d;
  logic [1:0]   rd_len_q, rd_len_d;
  logic         grant_q, grant_d;
  logic         last_grant_q, last_grant_d;

  // --------------------------------------------------------------------------
  // Write buffer state
  // --------------------------------------------------------------------------
  wr_state_t    wr_state_q, wr_state_d;
  logic [31:0]  wr_addr_q, wr_addr_d;
  logic [1:0]   wr_len_q, wr_len_d;
  logic         wr_line_q, wr_line_d;
  logic [3:0]   wr_strb_q, wr_strb_d;
  logic [127:0] wr_data_q, wr_data_d;
  logic [1:0]   wr_cnt_q, wr_cnt_d;

  logic         wr_accept;
  logic         rd_hazard;
  logic         i_elig;
  logic         d_elig;
  logic         rd_win_d;
  logic         ret_fwd;

  // The buffer is considered occupied from the accept cycle itself until the
  // write response, so a dcache refill can never slip past the write-back of
  // the same line, even when both are presented together.
  assign wr_accept = (wr_state_q == W_IDLE) && d_wr_req;
  assign rd_hazard = ((wr_state_q != W_IDLE) && (d_rd_addr[31:4] == wr_addr_q[31:4])) ||
                     (wr_accept && (d_rd_addr[31:4] == d_wr_addr[31:4]));

  assign i_elig = i_rd_req;
  assign d_elig = d_rd_req && !rd_hazard;

  // --------------------------------------------------------------------------
  // Read FSM: next state and handshake outputs
  // --------------------------------------------------------------------------
  always_comb begin
    rd_state_d   = rd_state_q;
    rd_addr_d    = rd_addr_q;
    rd_len_d     = rd_len_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    rd_win_d     = 1'b0;
    i_rd_rdy     = 1'b0;
    d_rd_rdy     = 1'b0;
    mem_rd_req   = 1'b0;

    unique case (rd_state_q)
      R_IDLE: begin
        if (i_elig || d_elig) begin
          // dcache wins when it is alone, or on a tie when icache went last.
          rd_win_d     = d_elig && (!i_elig || (last_grant_q == GNT_I));
          i_rd_rdy     = !rd_win_d;
          d_rd_rdy     = rd_win_d;
          rd_addr_d    = rd_win_d ? d_rd_addr : i_rd_addr;
          rd_len_d     = ((rd_win_d ? d_rd_type : i_rd_type) == TYPE_LINE) ? 2'd3 : 2'd0;
          grant_d      = rd_win_d ? GNT_D : GNT_I;
          last_grant_d = rd_win_d ? GNT_D : GNT_I;
          rd_state_d   = R_REQ;
        end
      end
      R_REQ: begin
        mem_rd_req = 1'b1;
        if (mem_rd_rdy) begin
          rd_state_d = R_DATA;
        end
      end
      R_DATA: begin
        if (mem_ret_valid && mem_ret_last) begin
          rd_state_d = R_IDLE;
        end
      end
      default: begin
        rd_state_d = R_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_state_q   <= R_IDLE;
      rd_addr_q    <= 32'd0;
      rd_len_q     <= 2'd0;
      grant_q      <= GNT_I;
      last_grant_q <= GNT_D;
    end else begin
      rd_state_q   <= rd_state_d;
      rd_addr_q    <= rd_addr_d;
      rd_len_q     <= rd_len_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign mem_rd_addr = rd_addr_q;
  assign mem_rd_len  = rd_len_q;

  // Return beats pass straight through to the granted client; anything the
  // memory presents outside the data phase is dropped.
  assign ret_fwd      = (rd_state_q == R_DATA) && mem_ret_valid;
  assign i_ret_valid  = ret_fwd && (grant_q == GNT_I);
  assign d_ret_valid  = ret_fwd && (grant_q == GNT_D);
  assign i_ret_last   = {1'b0, i_ret_valid && mem_ret_last};
  assign d_ret_last   = {1'b0, d_ret_valid && mem_ret_last};
  assign cli_ret_data = ret_fwd ? mem_ret_data : 32'd0;

  // --------------------------------------------------------------------------
  // Write FSM
  // --------------------------------------------------------------------------
  always_comb begin
    wr_state_d = wr_state_q;
    wr_addr_d  = wr_addr_q;
    wr_len_d   = wr_len_q;
    wr_line_d  = wr_line_q;
    wr_strb_d  = wr_strb_q;
    wr_data_d  = wr_data_q;
    wr_cnt_d   = wr_cnt_q;

    unique case (wr_state_q)
      W_IDLE: begin
        if (d_wr_req) begin
          wr_addr_d  = d_wr_addr;
          wr_line_d  = (d_wr_type == TYPE_LINE);
          wr_len_d   = (d_wr_type == TYPE_LINE) ? 2'd3 : 2'd0;
          wr_strb_d  = d_wr_wstrb;
          wr_data_d  = d_wr_data;
          wr_cnt_d   = 2'd0;
          wr_state_d = W_DATA;
        end
      end
      W_DATA: begin
        if (mem_wr_rdy) begin
          if (wr_cnt_q == wr_len_q) begin
            wr_state_d = W_RESP;
          end else begin
            wr_cnt_d = wr_cnt_q + 2'd1;
          end
        end
      end
      W_RESP: begin
        if (mem_wr_done) begin
          wr_state_d = W_IDLE;
        end
      end
      default: begin
        wr_state_d = W_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_state_q <= W_IDLE;
      wr_addr_q  <= 32'd0;
      wr_len_q   <= 2'd0;
      wr_line_q  <= 1'b0;
      wr_strb_q  <= 4'd0;
      wr_data_q  <= 128'd0;
      wr_cnt_q   <= 2'd0;
    end else begin
      wr_state_q <= wr_state_d;
      wr_addr_q  <= wr_addr_d;
      wr_len_q   <= wr_len_d;
      wr_line_q  <= wr_line_d;
      wr_strb_q  <= wr_strb_d;
      wr_data_q  <= wr_data_d;
      wr_cnt_q   <= wr_cnt_d;
    end
  end

  assign d_wr_rdy    = (wr_state_q == W_IDLE);
  assign mem_wr_req  = (wr_state_q == W_DATA);
  assign mem_wr_addr = wr_addr_q;
  assign mem_wr_len  = wr_len_q;
  assign mem_wr_strb = mem_wr_req ? (wr_line_q ? 4'hf : wr_strb_q) : 4'h0;
  assign mem_wr_data = mem_wr_req ? wr_data_q[{wr_cnt_q, 5'd0} +: 32] : 32'd0;
  assign mem_wr_last = mem_wr_req && (wr_cnt_q == wr_len_q);

endmodule
`default_nettype wire

// File: tb/tb_cache_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_cache_mem_arbiter
// Purpose  : Scoreboard bench for cache_mem_arbiter. Stimulus pushes expected
//            read returns, read address beats and write beats into queues; a
//            negedge monitor pops and compares whenever the DUT presents one.
//            Behavioural downstream models supply read data and write acks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cache_mem_arbiter;

  logic          clk;
  logic          reset;
  logic          i_rd_req, d_rd_req;
  logic [2:0]    i_rd_type, d_rd_type;
  logic [31:0]   i_rd_addr, d_rd_addr;
  logic          i_rd_rdy, d_rd_rdy;
  logic          i_ret_valid, d_ret_valid;
  logic [1:0]    i_ret_last, d_ret_last;
  logic [31:0]   cli_ret_data;
  logic          d_wr_req;
  logic [2:0]    d_wr_type;
  logic [31:0]   d_wr_addr;
  logic [3:0]    d_wr_wstrb;
  logic [127:0]  d_wr_data;
  logic          d_wr_rdy;
  logic          mem_rd_req;
  logic [31:0]   mem_rd_addr;
  logic [1:0]    mem_rd_len;
  logic          mem_rd_rdy;
  logic          mem_ret_valid;
  logic          mem_ret_last;
  logic [31:0]   mem_ret_data;
  logic          mem_wr_req;
  logic [31:0]   mem_wr_addr;
  logic [1:0]    mem_wr_len;
  logic [3:0]    mem_wr_strb;
  logic [31:0]   mem_wr_data;
  logic          mem_wr_last;
  logic          mem_wr_rdy;
  logic          mem_wr_done;

  cache_mem_arbiter dut (
    .clk(clk), .reset(reset),
    .i_rd_req(i_rd_req), .i_rd_type(i_rd_type), .i_rd_addr(i_rd_addr), .i_rd_rdy(i_rd_rdy),
    .d_rd_req(d_rd_req), .d_rd_type(d_rd_type), .d_rd_addr(d_rd_addr), .d_rd_rdy(d_rd_rdy),
    .i_ret_valid(i_ret_valid), .i_ret_last(i_ret_last),
    .d_ret_valid(d_ret_valid), .d_ret_last(d_ret_last),
    .cli_ret_data(cli_ret_data),
    .d_wr_req(d_wr_req), .d_wr_type(d_wr_type), .d_wr_addr(d_wr_addr),
    .d_wr_wstrb(d_wr_wstrb), .d_wr_data(d_wr_data), .d_wr_rdy(d_wr_rdy),
    .mem_rd_req(mem_rd_req), .mem_rd_addr(mem_rd_addr), .mem_rd_len(mem_rd_len),
    .mem_rd_rdy(mem_rd_rdy), .mem_ret_valid(mem_ret_valid), .mem_ret_last(mem_ret_last),
    .mem_ret_data(mem_ret_data),
    .mem_wr_req(mem_wr_req), .mem_wr_addr(mem_wr_addr), .mem_wr_len(mem_wr_len),
    .mem_wr_strb(mem_wr_strb), .mem_wr_data(mem_wr_data), .mem_wr_last(mem_wr_last),
    .mem_wr_rdy(mem_wr_rdy), .mem_wr_done(mem_wr_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // --------------------------------------------------------------------------
  // Scoreboard queues and counters
  // --------------------------------------------------------------------------
  typedef struct packed { logic cli; logic [31:0] data; logic last; } ret_t;
  typedef struct packed { logic [31:0] addr; logic [1:0] len; } rd_t;
  typedef struct packed {
    logic [31:0] addr; logic [1:0] len; logic [3:0] strb; logic [31:0] data; logic last;
  } wr_t;

  ret_t        exp_ret[$];
  rd_t         exp_rd[$];
  wr_t         exp_wr[$];
  logic [31:0] mem_data_q[$];

  int n_cmp = 0;
  int n_err = 0;

  int rd_delay   = 0;
  int done_delay = 0;
  bit wr_toggle  = 1'b0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic void push_ret(input logic cli, input logic [31:0] data, input logic last);
    ret_t e;
    e.cli = cli; e.data = data; e.last = last;
    exp_ret.push_back(e);
    mem_data_q.push_back(data);
  endfunction

  function automatic void push_rd(input logic [31:0] addr, input logic [1:0] len);
    rd_t e;
    e.addr = addr; e.len = len;
    exp_rd.push_back(e);
  endfunction

  function automatic void push_wr(input logic [31:0] addr, input logic [1:0] len, input logic [3:0] strb,
                                  input logic [31:0] data, input logic last);
    wr_t e;
    e.addr = addr; e.len = len; e.strb = strb; e.data = data; e.last = last;
    exp_wr.push_back(e);
  endfunction

  // --------------------------------------------------------------------------
  // Monitor: compares every DUT-presented transfer against the queues
  // --------------------------------------------------------------------------
  always @(negedge clk) begin
    if (!reset) begin
      if (i_ret_valid || d_ret_valid) begin
        if (exp_ret.size() == 0) begin
          chk("ret_unexpected", {i_ret_valid, d_ret_valid}, 2'b00);
        end else begin
          ret_t e;
          e = exp_ret.pop_front();
          chk("ret_client", {i_ret_valid, d_ret_valid}, e.cli ? 2'b01 : 2'b10);
          chk("ret_data", cli_ret_data, e.data);
          chk("ret_last", e.cli ? d_ret_last : i_ret_last, {1'b0, e.last});
        end
      end
      if (mem_rd_req && mem_rd_rdy) begin
        if (exp_rd.size() == 0) begin
          chk("rd_unexpected", mem_rd_addr, 32'hFFFF_FFFF);
        end else begin
          rd_t e;
          e = exp_rd.pop_front();
          chk("rd_addr", mem_rd_addr, e.addr);
          chk("rd_len", mem_rd_len, e.len);
        end
      end
      if (mem_wr_req && mem_wr_rdy) begin
        if (exp_wr.size() == 0) begin
          chk("wr_unexpected", mem_wr_data, 32'hFFFF_FFFF);
        end else begin
          wr_t e;
          e = exp_wr.pop_front();
          chk("wr_addr", mem_wr_addr, e.addr);
          chk("wr_len", mem_wr_len, e.len);
          chk("wr_strb", mem_wr_strb, e.strb);
          chk("wr_data", mem_wr_data, e.data);
          chk("wr_last", mem_wr_last, e.last);
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Downstream read model: address accept after rd_delay cycles, then len+1
  // consecutive beats taken from mem_data_q.
  // --------------------------------------------------------------------------
  initial begin
    int wait_cnt;
    int beats_left;
    bit in_data;
    mem_rd_rdy = 1'b0; mem_ret_valid = 1'b0; mem_ret_last = 1'b0; mem_ret_data = 32'd0;
    wait_cnt = 0; beats_left = 0; in_data = 1'b0;
    forever begin
      @(posedge clk); #1;
      mem_rd_rdy = 1'b0; mem_ret_valid = 1'b0; mem_ret_last = 1'b0; mem_ret_data = 32'd0;
      if (reset) begin
        wait_cnt = 0; beats_left = 0; in_data = 1'b0;
      end else if (in_data) begin
        mem_ret_valid = 1'b1;
        if (mem_data_q.size() > 0) mem_ret_data = mem_data_q.pop_front();
        else                       mem_ret_data = 32'hDEAD_BEEF;
        mem_ret_last = (beats_left == 1);
        beats_left--;
        if (beats_left == 0) in_data = 1'b0;
      end else if (mem_rd_req) begin
        if (wait_cnt >= rd_delay) begin
          mem_rd_rdy = 1'b1;
          beats_left = int'(mem_rd_len) + 1;
          in_data    = 1'b1;
          wait_cnt   = 0;
        end else begin
          wait_cnt++;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Downstream write model: ready either steady or toggling; done pulses
  // done_delay cycles after the last-beat handshake.
  // --------------------------------------------------------------------------
  initial begin
    bit fire;
    int done_cnt;
    mem_wr_rdy = 1'b0; mem_wr_done = 1'b0; done_cnt = -1;
    forever begin
      @(negedge clk);
      fire = mem_wr_req && mem_wr_rdy && mem_wr_last;
      @(posedge clk); #1;
      mem_wr_done = 1'b0;
      if (reset) begin
        done_cnt = -1; mem_wr_rdy = 1'b0;
      end else begin
        mem_wr_rdy = wr_toggle ? !mem_wr_rdy : 1'b1;
        if (fire) done_cnt = done_delay;
        if (done_cnt == 0) begin
          mem_wr_done = 1'b1; done_cnt = -1;
        end else if (done_cnt > 0) begin
          done_cnt--;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers
  // --------------------------------------------------------------------------
  task automatic check_reset_vals(input string tag);
    chk({tag, "_rd_side"}, {i_rd_rdy, d_rd_rdy, i_ret_valid, d_ret_valid, i_ret_last, d_ret_last, mem_rd_req}, 0);
    chk({tag, "_d_wr_rdy"}, d_wr_rdy, 1'b1);
    chk({tag, "_mem_rd_addr"}, mem_rd_addr, 32'd0);
    chk({tag, "_mem_rd_len"}, mem_rd_len, 2'd0);
    chk({tag, "_cli_ret_data"}, cli_ret_data, 32'd0);
    chk({tag, "_wr_ctl"}, {mem_wr_req, mem_wr_len, mem_wr_strb, mem_wr_last}, 0);
    chk({tag, "_mem_wr_addr"}, mem_wr_addr, 32'd0);
    chk({tag, "_mem_wr_data"}, mem_wr_data, 32'd0);
  endtask

  task automatic drain(input string tag);
    bit done;
    done = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (exp_ret.size() == 0 && exp_rd.size() == 0 && exp_wr.size() == 0 && d_wr_rdy) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) chk({tag, "_drain_timeout"}, 1'b1, 1'b0);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_wr_done(input string tag, input bit watch_d_rd);
    bit seen;
    bit bad;
    seen = 1'b0; bad = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (d_wr_rdy) bad = 1'b1;
      if (watch_d_rd && d_rd_rdy) bad = 1'b1;
      if (mem_wr_done) begin
        seen = 1'b1;
        break;
      end
    end
    chk({tag, "_done_seen"}, seen, 1'b1);
    chk({tag, "_held_off"}, bad, 1'b0);
  endtask

  // --------------------------------------------------------------------------
  // Directed test sequence
  // --------------------------------------------------------------------------
  initial begin
    int ng;
    int seen;
    reset = 1'b1;
    i_rd_req = 1'b0; i_rd_type = 3'b000; i_rd_addr = 32'd0;
    d_rd_req = 1'b0; d_rd_type = 3'b000; d_rd_addr = 32'd0;
    d_wr_req = 1'b0; d_wr_type = 3'b000; d_wr_addr = 32'd0;
    d_wr_wstrb = 4'd0; d_wr_data = 128'd0;

    // Reset state
    repeat (2) @(negedge clk);
    check_reset_vals("reset");
    @(posedge clk); #1;
    reset = 1'b0;

    // Round-robin: both clients request continuously; order must be I,D,I,D
    rd_delay = 0;
    push_rd(32'h4000, 2'd0); push_ret(1'b0, 32'h11, 1'b1);
    push_rd(32'h5000, 2'd0); push_ret(1'b1, 32'h22, 1'b1);
    push_rd(32'h4000, 2'd0); push_ret(1'b0, 32'h33, 1'b1);
    push_rd(32'h5000, 2'd0); push_ret(1'b1, 32'h44, 1'b1);
    @(posedge clk); #1;
    i_rd_req = 1'b1; i_rd_type = 3'b000; i_rd_addr = 32'h4000;
    d_rd_req = 1'b1; d_rd_type = 3'b001; d_rd_addr = 32'h5000;
    ng = 0;
    for (int c = 0; c < 200 && ng < 4; c++) begin
      @(negedge clk);
      if (i_rd_rdy || d_rd_rdy) begin
        chk("grant_seq", {i_rd_rdy, d_rd_rdy}, (ng % 2 == 0) ? 2'b10 : 2'b01);
        ng++;
      end
      if (ng < 4) begin
        @(posedge clk); #1;
      end
    end
    chk("grant_count", ng, 4);
    @(posedge clk); #1;
    i_rd_req = 1'b0; d_rd_req = 1'b0;
    drain("rr");

    // icache line read @0x1000, address accepted after two wait cycles
    rd_delay = 2;
    push_rd(32'h1000, 2'd3);
    for (int k = 0; k < 4; k++) push_ret(1'b0, 32'hA0 + k, k == 3);
    @(posedge clk); #1;
    i_rd_req = 1'b1; i_rd_type = 3'b100; i_rd_addr = 32'h1000;
    @(negedge clk);
    chk("line_i_rd_rdy", {i_rd_rdy, d_rd_rdy}, 2'b10);
    @(posedge clk); #1;
    i_rd_req = 1'b0;
    @(negedge clk);
    chk("line_mem_rd_req", mem_rd_req, 1'b1);
    chk("line_mem_rd_len", mem_rd_len, 2'd3);
    drain("line_rd");

    // Line write @0x2000 with toggling write ready
    wr_toggle = 1'b1; done_delay = 2;
    for (int k = 0; k < 4; k++) push_wr(32'h2000, 2'd3, 4'hf, 32'hC0DE_0000 + k, k == 3);
    @(posedge clk); #1;
    d_wr_req = 1'b1; d_wr_type = 3'b100; d_wr_addr = 32'h2000; d_wr_wstrb = 4'b0000;
    d_wr_data = {32'hC0DE_0003, 32'hC0DE_0002, 32'hC0DE_0001, 32'hC0DE_0000};
    @(negedge clk);
    chk("wr_line_accept_rdy", d_wr_rdy, 1'b1);
    @(posedge clk); #1;
    d_wr_req = 1'b0;
    wait_wr_done("wr_line", 1'b0);
    @(negedge clk);
    chk("wr_line_rdy_back", d_wr_rdy, 1'b1);
    drain("wr_line");

    // Hazard: pending write-back to 0x2000 line blocks dcache read of 0x2008
    wr_toggle = 1'b0; done_delay = 20; rd_delay = 0;
    for (int k = 0; k < 4; k++) push_wr(32'h2000, 2'd3, 4'hf, 32'h5A00_0000 + k, k == 3);
    push_rd(32'h3000, 2'd3);
    for (int k = 0; k < 4; k++) push_ret(1'b0, 32'hB0 + k, k == 3);
    push_rd(32'h2008, 2'd3);
    for (int k = 0; k < 4; k++) push_ret(1'b1, 32'hD0 + k, k == 3);
    @(posedge clk); #1;
    d_wr_req = 1'b1; d_wr_type = 3'b100; d_wr_addr = 32'h2000;
    d_wr_data = {32'h5A00_0003, 32'h5A00_0002, 32'h5A00_0001, 32'h5A00_0000};
    @(negedge clk);
    chk("hz_wr_accept", d_wr_rdy, 1'b1);
    @(posedge clk); #1;
    d_wr_req = 1'b0;
    i_rd_req = 1'b1; i_rd_type = 3'b100; i_rd_addr = 32'h3000;
    d_rd_req = 1'b1; d_rd_type = 3'b100; d_rd_addr = 32'h2008;
    @(negedge clk);
    chk("hz_first_grant", {i_rd_rdy, d_rd_rdy}, 2'b10);
    @(posedge clk); #1;
    i_rd_req = 1'b0;
    wait_wr_done("hz", 1'b1);
    @(negedge clk);
    chk("hz_release", {d_wr_rdy, d_rd_rdy}, 2'b11);
    @(posedge clk); #1;
    d_rd_req = 1'b0;
    drain("hz");

    // Single-beat write, partial strobe
    done_delay = 0;
    push_wr(32'h6004, 2'd0, 4'b0011, 32'h0000_1234, 1'b1);
    @(posedge clk); #1;
    d_wr_req = 1'b1; d_wr_type = 3'b010; d_wr_addr = 32'h6004; d_wr_wstrb = 4'b0011;
    d_wr_data = {96'd0, 32'h0000_1234};
    @(posedge clk); #1;
    d_wr_req = 1'b0;
    drain("wr_single");

    // Reset asserted while the third beat of an icache line is on the bus
    rd_delay = 0;
    push_rd(32'h7000, 2'd3);
    push_ret(1'b0, 32'hE0, 1'b0);
    push_ret(1'b0, 32'hE1, 1'b0);
    mem_data_q.push_back(32'hE2);
    mem_data_q.push_back(32'hE3);
    @(posedge clk); #1;
    i_rd_req = 1'b1; i_rd_type = 3'b100; i_rd_addr = 32'h7000;
    @(posedge clk); #1;
    i_rd_req = 1'b0;
    seen = 0;
    for (int c = 0; c < 100 && seen < 2; c++) begin
      @(negedge clk);
      if (i_ret_valid) seen++;
    end
    chk("mid_reset_beats_seen", seen, 2);
    @(posedge clk); #2;
    reset = 1'b1;
    mem_data_q.delete();
    @(negedge clk);
    check_reset_vals("mid_reset");
    @(posedge clk); #1;
    reset = 1'b0;

    // Fresh icache read after the mid-burst reset
    rd_delay = 1;
    push_rd(32'h7100, 2'd3);
    for (int k = 0; k < 4; k++) push_ret(1'b0, 32'hF0 + k, k == 3);
    @(posedge clk); #1;
    i_rd_req = 1'b1; i_rd_type = 3'b100; i_rd_addr = 32'h7100;
    @(negedge clk);
    chk("post_reset_rdy", i_rd_rdy, 1'b1);
    @(posedge clk); #1;
    i_rd_req = 1'b0;
    drain("post_reset");

    chk("left_ret", exp_ret.size(), 0);
    chk("left_rd", exp_rd.size(), 0);
    chk("left_wr", exp_wr.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
